// File: rtl/dmem_access_ctrl.sv
// MEM-stage data-memory access sequencer.
// Turns the EX/MEM access fields into one req/ack transaction on the data
// port, holds the pipeline with `stall` until the access resolves, and
// aligns/extends load data for write-back. Illegal accesses are flagged and
// never reach the bus; a missing ack is abandoned after TIMEOUT WAIT cycles.
//
// Handshake: dmem_req rises at the edge leaving IDLE and stays high, with
// dmem_we/addr/be/wdata frozen, for every WAIT cycle. A transfer completes on
// the first WAIT cycle where dmem_ack=1 (dmem_rdata valid in that same cycle);
// dmem_req drops at that edge. dmem_ack is ignored in IDLE and DONE.
module dmem_access_ctrl #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        memRead,
    input  logic        memWrite,
    input  logic [2:0]  fnc3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        stall,
    output logic [31:0] load_data,
    output logic        load_valid,
    output logic        misalign,
    output logic        bus_err,
    output logic [1:0]  dbg_state
);

    localparam int CW = $clog2(TIMEOUT);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [1:0]    lat_lo;     // byte offset captured at request
    logic [2:0]    lat_fnc3;   // size code captured at request

    logic          acc;
    logic          size_ok;
    logic          align_ok;
    logic          legal;
    logic [3:0]    be_next;
    logic [31:0]   wdata_next;
    logic [31:0]   shifted;
    logic [31:0]   load_ext;

    // Decode legality, byte enables and store lane replication for the
    // access currently presented by the EX/MEM register.
    always_comb begin
        acc        = memRead | memWrite;
        size_ok    = 1'b0;
        align_ok   = 1'b1;
        be_next    = 4'b1111;
        wdata_next = wdata;
        case (fnc3)
            3'b000, 3'b001, 3'b010: size_ok = 1'b1;
            3'b100, 3'b101:         size_ok = ~memWrite;  // unsigned codes are load-only
            default:                size_ok = 1'b0;
        endcase
        case (fnc3[1:0])
            2'b00: begin
                be_next    = 4'b0001 << addr[1:0];
                wdata_next = {4{wdata[7:0]}};
            end
            2'b01: begin
                align_ok   = ~addr[0];
                be_next    = 4'b0011 << addr[1:0];
                wdata_next = {2{wdata[15:0]}};
            end
            default: begin
                align_ok   = (addr[1:0] == 2'b00);
                be_next    = 4'b1111;
                wdata_next = wdata;
            end
        endcase
        legal = size_ok & align_ok;
    end

    // Move the addressed lane to bit 0 and extend according to the captured size code.
    always_comb begin
        shifted  = dmem_rdata >> {lat_lo, 3'b000};
        load_ext = shifted;
        case (lat_fnc3)
            3'b000:  load_ext = {{24{shifted[7]}}, shifted[7:0]};
            3'b001:  load_ext = {{16{shifted[15]}}, shifted[15:0]};
            3'b100:  load_ext = {24'd0, shifted[7:0]};
            3'b101:  load_ext = {16'd0, shifted[15:0]};
            default: load_ext = shifted;
        endcase
    end

    // Stall from the cycle a legal access appears until the ack/timeout edge;
    // DONE releases so the pipeline advances without re-issuing.
    assign stall     = rst & (((state == S_IDLE) & acc & legal) | (state == S_WAIT));
    assign dbg_state = state;

    // Access sequencer with registered bus fields and result pulses.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= S_IDLE;
            cnt        <= '0;
            lat_lo     <= 2'b00;
            lat_fnc3   <= 3'b000;
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_addr  <= 32'd0;
            dmem_be    <= 4'd0;
            dmem_wdata <= 32'd0;
            load_data  <= 32'd0;
            load_valid <= 1'b0;
            misalign   <= 1'b0;
            bus_err    <= 1'b0;
        end else begin
            load_valid <= 1'b0;
            misalign   <= 1'b0;
            bus_err    <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (acc) begin
                        if (legal) begin
                            dmem_req   <= 1'b1;
                            dmem_we    <= memWrite;
                            dmem_addr  <= {addr[31:2], 2'b00};
                            dmem_be    <= be_next;
                            dmem_wdata <= wdata_next;
                            lat_lo     <= addr[1:0];
                            lat_fnc3   <= fnc3;
                            cnt        <= '0;
                            state      <= S_WAIT;
                        end else begin
                            misalign <= 1'b1;
                            state    <= S_DONE;
                        end
                    end
                end
                S_WAIT: begin
                    if (dmem_ack) begin
                        // ack is checked first so it wins over a coincident timeout
                        dmem_req <= 1'b0;
                        if (!dmem_we) begin
                            load_data  <= load_ext;
                            load_valid <= 1'b1;
                        end
                        state <= S_DONE;
                    end else if (cnt == CNT_LAST) begin
                        dmem_req <= 1'b0;
                        bus_err  <= 1'b1;
                        state    <= S_DONE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Bench for dmem_access_ctrl: directed vector table, randomized accesses
// checked against a byte-lane arithmetic model, and hand-written sequences
// for reset during WAIT and late acks.
module tb_dmem_access_ctrl;

    localparam int TIMEOUT = 4;
    localparam int NV      = 15;
    localparam int NRAND   = 150;

    logic        clk;
    logic        rst;
    logic        memRead;
    logic        memWrite;
    logic [2:0]  fnc3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;
    logic        stall;
    logic [31:0] load_data;
    logic        load_valid;
    logic        misalign;
    logic        bus_err;
    logic [1:0]  dbg_state;

    dmem_access_ctrl #(.TIMEOUT(TIMEOUT)) dut (
        .clk        (clk),
        .rst        (rst),
        .memRead    (memRead),
        .memWrite   (memWrite),
        .fnc3       (fnc3),
        .addr       (addr),
        .wdata      (wdata),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .dmem_addr  (dmem_addr),
        .dmem_be    (dmem_be),
        .dmem_wdata (dmem_wdata),
        .dmem_ack   (dmem_ack),
        .dmem_rdata (dmem_rdata),
        .stall      (stall),
        .load_data  (load_data),
        .load_valid (load_valid),
        .misalign   (misalign),
        .bus_err    (bus_err),
        .dbg_state  (dbg_state)
    );

    typedef struct {
        logic        rd;
        logic        wr;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] rdata;
        int          ack_dly;   // wait states before ack; -1 = never
        logic        legal;
        logic [3:0]  be;
        logic [31:0] wdo;
        logic [31:0] ld;
    } vec_t;

    int          checks;
    int          errors;
    logic [31:0] exp_q[$];
    logic [31:0] cur_ld;
    vec_t        tbl[NV];

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    // ---------------- checkers ----------------
    task automatic chk1(input string n, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0b expected %0b", n, act, exp);
        end
    endtask

    task automatic chk32(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", n, act, exp);
        end
    endtask

    // Scoreboard: every load_valid consumes one expected load; otherwise load_data must hold.
    task automatic sb_sample(input string n);
        logic [31:0] e;
        if (load_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk32({n, "_unexpected_load"}, load_data, cur_ld);
                errors += (load_data === cur_ld) ? 1 : 0;
            end else begin
                e = exp_q.pop_front();
                chk32({n, "_load_data"}, load_data, e);
                cur_ld = e;
            end
        end else begin
            chk32({n, "_load_hold"}, load_data, cur_ld);
        end
    endtask

    task automatic check_reset_vals(input string n);
        chk1 ({n, "_req"},        dmem_req,   1'b0);
        chk1 ({n, "_we"},         dmem_we,    1'b0);
        chk32({n, "_addr"},       dmem_addr,  32'd0);
        chk32({n, "_be"},         {28'd0, dmem_be}, 32'd0);
        chk32({n, "_wdata"},      dmem_wdata, 32'd0);
        chk32({n, "_load_data"},  load_data,  32'd0);
        chk1 ({n, "_load_valid"}, load_valid, 1'b0);
        chk1 ({n, "_misalign"},   misalign,   1'b0);
        chk1 ({n, "_bus_err"},    bus_err,    1'b0);
        chk1 ({n, "_stall"},      stall,      1'b0);
    endtask

    // ---------------- reference model ----------------
    function automatic vec_t model_fill(input vec_t t);
        vec_t        r;
        int          nb;
        int          lo;
        bit          valid;
        logic [31:0] v;
        r  = t;
        lo = int'(t.addr % 4);
        nb = (t.f3 % 4 == 0) ? 1 : (t.f3 % 4 == 1) ? 2 : 4;
        if (t.wr) valid = (t.f3 <= 2);
        else      valid = (t.f3 <= 2) || (t.f3 == 4) || (t.f3 == 5);
        r.legal = valid && ((t.addr % nb) == 0);
        r.be  = 4'd0;
        r.wdo = 32'd0;
        for (int i = 0; i < 4; i++) begin
            if (i >= lo && i < lo + nb) r.be[i] = 1'b1;
            r.wdo[8*i +: 8] = t.wd[8*(i % nb) +: 8];
        end
        v = t.rdata >> (8 * lo);
        if (nb == 1) begin
            v = v % 256;
            if (t.f3 == 0 && v >= 128) v = v + 32'hFFFFFF00;
        end else if (nb == 2) begin
            v = v % 65536;
            if (t.f3 == 1 && v >= 32768) v = v + 32'hFFFF0000;
        end
        r.ld = v;
        return r;
    endfunction

    function automatic vec_t mk(input logic rd, input logic wr, input logic [2:0] f3,
                                input logic [31:0] a, input logic [31:0] wd,
                                input logic [31:0] rdata, input int dly, input logic legal,
                                input logic [3:0] be, input logic [31:0] wdo,
                                input logic [31:0] ld);
        vec_t r;
        r.rd = rd; r.wr = wr; r.f3 = f3; r.addr = a; r.wd = wd; r.rdata = rdata;
        r.ack_dly = dly; r.legal = legal; r.be = be; r.wdo = wdo; r.ld = ld;
        return r;
    endfunction

    // ---------------- driver ----------------
    // Window w is the half-cycle after the w-th edge following presentation.
    task automatic run_access(input vec_t t, input string nm);
        int    n;
        int    ackw;
        int    last;
        bit    is_wr;
        bit    exp_req;
        string tag;
        is_wr = t.wr;
        ackw  = -1;
        if (!t.legal)                                   n = 2;
        else if (t.ack_dly < 0 || t.ack_dly >= TIMEOUT) n = TIMEOUT + 2;
        else begin
            n    = t.ack_dly + 3;
            ackw = t.ack_dly + 1;
        end
        last = n - 1;
        if (t.legal && !is_wr && ackw > 0) exp_q.push_back(t.ld);
        for (int w = 0; w < n; w++) begin
            @(negedge clk);
            if (w == 0) begin
                memRead  = t.rd;
                memWrite = t.wr;
                fnc3     = t.f3;
                addr     = t.addr;
                wdata    = t.wd;
            end
            if (w == ackw)                 dmem_ack = 1'b1;
            else if (w == 0 || w == last)  dmem_ack = 1'($urandom_range(0, 1));
            else                           dmem_ack = 1'b0;
            dmem_rdata = (w == ackw) ? t.rdata : $urandom;
            #1;
            tag     = $sformatf("%s_w%0d", nm, w);
            exp_req = t.legal && w >= 1 && w < last;
            chk1({tag, "_stall"},      stall,      t.legal && w < last);
            chk1({tag, "_req"},        dmem_req,   exp_req);
            chk1({tag, "_misalign"},   misalign,   !t.legal && w == 1);
            chk1({tag, "_bus_err"},    bus_err,    t.legal && ackw < 0 && w == last);
            chk1({tag, "_load_valid"}, load_valid, t.legal && !is_wr && ackw > 0 && w == last);
            if (exp_req) begin
                chk1 ({tag, "_we"},   dmem_we,   is_wr);
                chk32({tag, "_addr"}, dmem_addr, {t.addr[31:2], 2'b00});
                chk32({tag, "_be"},   {28'd0, dmem_be}, {28'd0, t.be});
                if (is_wr) chk32({tag, "_wdata"}, dmem_wdata, t.wdo);
            end
            sb_sample(tag);
        end
        // pipeline advances: next slot is a bubble
        @(negedge clk);
        memRead    = 1'b0;
        memWrite   = 1'b0;
        dmem_ack   = 1'($urandom_range(0, 1));
        dmem_rdata = $urandom;
        #1;
        chk1({nm, "_idle_stall"}, stall,    1'b0);
        chk1({nm, "_idle_req"},   dmem_req, 1'b0);
        chk1({nm, "_idle_pulse"}, misalign | bus_err | load_valid, 1'b0);
        sb_sample({nm, "_idle"});
    endtask

    // ---------------- main sequence ----------------
    initial begin
        vec_t t;
        logic [31:0] a;
        checks = 0;
        errors = 0;
        cur_ld = 32'd0;
        rst = 1'b0; memRead = 1'b0; memWrite = 1'b0; fnc3 = 3'b000;
        addr = 32'd0; wdata = 32'd0; dmem_ack = 1'b0; dmem_rdata = 32'd0;

        tbl[0]  = mk(1, 0, 3'b010, 32'h100, 32'h0,        32'hDEADBEEF, 0, 1, 4'b1111, 32'h0,        32'hDEADBEEF);
        tbl[1]  = mk(1, 0, 3'b000, 32'h103, 32'h0,        32'h80FFFFFF, 0, 1, 4'b1000, 32'h0,        32'hFFFFFF80);
        tbl[2]  = mk(1, 0, 3'b100, 32'h103, 32'h0,        32'h80FFFFFF, 1, 1, 4'b1000, 32'h0,        32'h00000080);
        tbl[3]  = mk(1, 0, 3'b101, 32'h102, 32'h0,        32'hBEEF1234, 0, 1, 4'b1100, 32'h0,        32'h0000BEEF);
        tbl[4]  = mk(0, 1, 3'b000, 32'h201, 32'h000000A5, 32'h0,        1, 1, 4'b0010, 32'hA5A5A5A5, 32'h0);
        tbl[5]  = mk(0, 1, 3'b001, 32'h202, 32'h0000BEEF, 32'h0,        2, 1, 4'b1100, 32'hBEEFBEEF, 32'h0);
        tbl[6]  = mk(1, 0, 3'b010, 32'h102, 32'h0,        32'h0,        0, 0, 4'b0000, 32'h0,        32'h0);
        tbl[7]  = mk(0, 1, 3'b011, 32'h300, 32'h0,        32'h0,        0, 0, 4'b0000, 32'h0,        32'h0);
        tbl[8]  = mk(1, 0, 3'b010, 32'h400, 32'h0,        32'h0,       -1, 1, 4'b1111, 32'h0,        32'h0);
        tbl[9]  = mk(1, 0, 3'b001, 32'h102, 32'h0,        32'h80011234, 3, 1, 4'b1100, 32'h0,        32'hFFFF8001);
        tbl[10] = mk(1, 1, 3'b010, 32'h10C, 32'h12345678, 32'h0,        1, 1, 4'b1111, 32'h12345678, 32'h0);
        tbl[11] = mk(1, 0, 3'b001, 32'h101, 32'h0,        32'h0,        0, 0, 4'b0000, 32'h0,        32'h0);
        tbl[12] = mk(1, 0, 3'b110, 32'h100, 32'h0,        32'h0,        0, 0, 4'b0000, 32'h0,        32'h0);
        tbl[13] = mk(0, 1, 3'b100, 32'h100, 32'h0,        32'h0,        0, 0, 4'b0000, 32'h0,        32'h0);
        tbl[14] = mk(1, 0, 3'b000, 32'h102, 32'h0,        32'h007F0000, 1, 1, 4'b0100, 32'h0,        32'h0000007F);

        // Reset values, and stall held low while reset is asserted.
        repeat (3) @(negedge clk);
        memRead = 1'b1; fnc3 = 3'b010; addr = 32'h0;
        #1;
        check_reset_vals("reset");
        @(negedge clk);
        memRead = 1'b0;
        rst     = 1'b1;

        // Directed table.
        for (int i = 0; i < NV; i++) run_access(tbl[i], $sformatf("vec%0d", i));

        // Late ack after a timeout must be ignored.
        run_access(tbl[8], "late_to");
        @(negedge clk);
        dmem_ack = 1'b1; dmem_rdata = 32'hCAFEF00D;
        #1;
        @(negedge clk);
        dmem_ack = 1'b0;
        #1;
        chk1("late_ack_lv",   load_valid, 1'b0);
        chk1("late_ack_berr", bus_err,    1'b0);
        chk1("late_ack_req",  dmem_req,   1'b0);
        sb_sample("late_ack");

        // Randomized accesses against the model.
        for (int i = 0; i < NRAND; i++) begin
            t.rd = 1'($urandom_range(0, 1));
            t.wr = t.rd ? 1'($urandom_range(0, 1)) : 1'b1;
            if ($urandom_range(0, 3) != 0) begin
                case ($urandom_range(0, 4))
                    0: t.f3 = 3'b000;
                    1: t.f3 = 3'b001;
                    2: t.f3 = 3'b010;
                    3: t.f3 = 3'b100;
                    default: t.f3 = 3'b101;
                endcase
            end else begin
                t.f3 = 3'($urandom_range(0, 7));
            end
            a = $urandom;
            if ($urandom_range(0, 1) == 1) a = a & 32'hFFFFFFFC;
            t.addr  = a;
            t.wd    = $urandom;
            t.rdata = $urandom;
            t.ack_dly = $urandom_range(0, TIMEOUT);
            if (t.ack_dly == TIMEOUT) t.ack_dly = -1;
            t = model_fill(t);
            run_access(t, $sformatf("rnd%0d", i));
        end

        // Reset asserted in the 2nd WAIT cycle of a load acked after 3 wait states.
        @(negedge clk);
        memRead = 1'b1; memWrite = 1'b0; fnc3 = 3'b010; addr = 32'h500; dmem_ack = 1'b0;
        #1;
        chk1("rw_stall_idle", stall, 1'b1);
        @(negedge clk);
        #1;
        chk1("rw_req_wait1", dmem_req, 1'b1);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk1("rw_stall_in_rst", stall, 1'b0);
        @(negedge clk);
        memRead = 1'b0;
        #1;
        check_reset_vals("rw_after_rst");
        cur_ld = 32'd0;
        @(negedge clk);
        rst = 1'b1; dmem_ack = 1'b1; dmem_rdata = 32'h12345678;
        #1;
        chk1("rw_req_late", dmem_req, 1'b0);
        @(negedge clk);
        dmem_ack = 1'b0;
        #1;
        chk1("rw_no_load_valid", load_valid, 1'b0);
        sb_sample("rw_end");

        chk32("sb_drain", exp_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
